// File: rtl/mips_pkg.sv
// Shared types and constants for the fetch stage of the MIPS datapath.
package mips_pkg;

  localparam int          WORD_W       = 32;
  localparam logic [31:0] PC_STEP      = 32'd4;
  localparam logic [31:0] RESET_VECTOR = 32'h00000000;

  // One prefetch buffer slot: the fetch address and the word read there.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Instruction addresses are word aligned; low two bits are dropped.
  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular prefetch buffer of {pc, instr} entries with a synchronous flush.
module fetch_fifo
  import mips_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  fetch_entry_t           wdata,
  output fetch_entry_t           rdata,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Storage is cleared on reset so an empty buffer never exposes stale data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push && !flush) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  // Next pointers and occupancy; a flush discards everything, including a same-cycle pop.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rdata = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, fills the prefetch buffer from instr_mem, handles redirects.
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_VECTOR,
  parameter int          DEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [WORD_W-1:0] imem_addr,
  input  logic [WORD_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [WORD_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_instr,
  output logic [WORD_W-1:0] out_pc,
  output logic [WORD_W-1:0] out_pc_plus4,
  output logic              misalign_err
);

  localparam int               CNT_W     = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic             misalign_q, misalign_d;
  logic [CNT_W-1:0] count;
  logic             push, pop;
  fetch_entry_t     wr_entry, head;

  // Redirect wins over fetching; a full buffer only accepts a word when the head leaves.
  assign pop      = out_valid & out_ready;
  assign push     = !redirect_valid & ((count < DEPTH_CNT) | pop);
  assign wr_entry = '{pc: fetch_pc_q, instr: imem_rdata};

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .wdata (wr_entry),
    .rdata (head),
    .count (count)
  );

  // Next fetch address and sticky misaligned-target flag.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    misalign_d = misalign_q;
    if (redirect_valid) begin
      fetch_pc_d = align_pc(redirect_pc);
      misalign_d = misalign_q | (redirect_pc[1:0] != 2'b00);
    end else if (push) begin
      fetch_pc_d = fetch_pc_q + PC_STEP;
    end
  end

  // PC and error flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      misalign_q <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      misalign_q <= misalign_d;
    end
  end

  assign imem_addr    = fetch_pc_q;
  assign out_valid    = (count != '0);
  assign out_instr    = head.instr;
  assign out_pc       = head.pc;
  assign out_pc_plus4 = out_valid ? (head.pc + PC_STEP) : '0;
  assign misalign_err = misalign_q;

endmodule
